// File: rtl/adc_frame_packer_pkg.sv
// Shared types and field positions for the ADC frame packer: control bits,
// FSM state encoding, diagnostics layout and the FIFO entry format.
package adc_frame_packer_pkg;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_CLR_CNT = 1;

  localparam int DIAG_RUN       = 31;
  localparam int DIAG_STATE_LSB = 29;
  localparam int DIAG_FIFO_ERR  = 28;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_PAD     = 2'd2,
    ST_SKIP    = 2'd3
  } state_t;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } fifo_word_t;

  function automatic logic [15:0] sat16(input logic [31:0] v);
    return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
  endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// AXI-Stream link from the frame packer to the DMA.
interface adc_frame_packer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_frame_fifo.sv
// Synchronous first-word-fall-through FIFO holding {tlast, data} entries.
// A push that finds no room is dropped and latches a sticky error.
module adc_frame_fifo
  import adc_frame_packer_pkg::*;
#(
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fifo_word_t    din,
  input  logic          pop,
  output fifo_word_t    dout,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic          err
);

  fifo_word_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push on a full FIFO is legal then.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      err    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && !do_push) err <= 1'b1;
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/adc_frame_packer.sv
// Packs 16-bit ADC samples into 32-bit words, frames them and streams them out
// through a FWFT FIFO; frames that cannot be buffered whole are skipped.
//
// state   | meaning
// IDLE    | waiting for a sample with RUN=1, admission decided on it
// CAPTURE | packing samples into words and pushing them
// PAD     | RUN dropped mid-frame; flush half-word, then zero words to tlast
// SKIP    | no room for the frame; discard one frame's worth of samples
module adc_frame_packer
  import adc_frame_packer_pkg::*;
#(
  parameter int FRAME_WORDS = 256,
  parameter int FIFO_DEPTH  = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               adc_valid,
  input  logic [15:0]        adc_data,
  input  logic [31:0]        reg_control,
  output logic [31:0]        reg_frame_counter,
  output logic [31:0]        reg_overflow_counter,
  output logic [31:0]        reg_diagnostics,
  output logic [31:0]        reg_control_clear_mask,
  adc_frame_packer_if.master m_axis
);

  localparam int WW = $clog2(FRAME_WORDS);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WW-1:0] WCNT_LAST = WW'(FRAME_WORDS - 1);

  state_t        state, state_nxt;
  logic          half_valid, half_valid_nxt;
  logic [15:0]   half_data, half_data_nxt;
  logic [WW-1:0] wcnt, wcnt_nxt;

  logic          run;
  logic          clr;
  logic          unused_ctrl;
  logic          wcnt_last;
  logic          admit_ok;
  logic          ovf_inc;
  logic          fifo_push;
  fifo_word_t    push_word;
  fifo_word_t    fifo_dout;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          fifo_err;
  logic          handshake;
  logic [31:0]   diag_nxt;

  assign run         = reg_control[CTRL_RUN];
  assign clr         = reg_control[CTRL_CLR_CNT];
  assign unused_ctrl = ^reg_control[31:2];
  assign wcnt_last   = (wcnt == WCNT_LAST);
  assign admit_ok    = (32'(FIFO_DEPTH) - 32'(fifo_level)) >= 32'(FRAME_WORDS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      half_valid <= 1'b0;
      half_data  <= '0;
      wcnt       <= '0;
    end else begin
      state      <= state_nxt;
      half_valid <= half_valid_nxt;
      half_data  <= half_data_nxt;
      wcnt       <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    half_valid_nxt = half_valid;
    half_data_nxt  = half_data;
    wcnt_nxt       = wcnt;
    fifo_push      = 1'b0;
    push_word      = '0;
    ovf_inc        = 1'b0;
    case (state)
      ST_IDLE: begin
        // The triggering sample is the frame's first sample either way.
        if (adc_valid && run) begin
          half_valid_nxt = 1'b1;
          half_data_nxt  = adc_data;
          wcnt_nxt       = '0;
          if (admit_ok) begin
            state_nxt = ST_CAPTURE;
          end else begin
            state_nxt = ST_SKIP;
            ovf_inc   = 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        if (!run) begin
          state_nxt = ST_PAD;
        end else if (adc_valid) begin
          if (half_valid) begin
            fifo_push      = 1'b1;
            push_word.last = wcnt_last;
            push_word.data = {adc_data, half_data};
            half_valid_nxt = 1'b0;
            if (wcnt_last) begin
              state_nxt = ST_IDLE;
              wcnt_nxt  = '0;
            end else begin
              wcnt_nxt = wcnt + 1'b1;
            end
          end else begin
            half_valid_nxt = 1'b1;
            half_data_nxt  = adc_data;
          end
        end
      end
      ST_PAD: begin
        // Room for the whole frame was reserved at admission.
        fifo_push      = 1'b1;
        push_word.last = wcnt_last;
        push_word.data = half_valid ? {16'h0000, half_data} : 32'h0;
        half_valid_nxt = 1'b0;
        if (wcnt_last) begin
          state_nxt = ST_IDLE;
          wcnt_nxt  = '0;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      ST_SKIP: begin
        if (!run) begin
          state_nxt      = ST_IDLE;
          half_valid_nxt = 1'b0;
          wcnt_nxt       = '0;
        end else if (adc_valid) begin
          if (half_valid) begin
            half_valid_nxt = 1'b0;
            if (wcnt_last) begin
              state_nxt = ST_IDLE;
              wcnt_nxt  = '0;
            end else begin
              wcnt_nxt = wcnt + 1'b1;
            end
          end else begin
            half_valid_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  adc_frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (push_word),
    .pop   (handshake),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .level (fifo_level),
    .err   (fifo_err)
  );

  // Outputs read as zero while the FIFO is empty so nothing stale leaks out.
  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_empty ? 32'h0 : fifo_dout.data;
  assign m_axis.tlast  = !fifo_empty && fifo_dout.last;
  assign handshake     = m_axis.tvalid && m_axis.tready;

  always_comb begin
    diag_nxt                          = '0;
    diag_nxt[DIAG_RUN]                = run;
    diag_nxt[DIAG_STATE_LSB +: 2]     = state;
    diag_nxt[DIAG_FIFO_ERR]           = fifo_err;
    diag_nxt[15:0]                    = sat16(32'(fifo_level));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_frame_counter      <= '0;
      reg_overflow_counter   <= '0;
      reg_diagnostics        <= '0;
      reg_control_clear_mask <= '0;
    end else begin
      if (clr) reg_frame_counter <= '0;
      else if (handshake && m_axis.tlast) reg_frame_counter <= reg_frame_counter + 1'b1;
      if (clr) reg_overflow_counter <= '0;
      else if (ovf_inc) reg_overflow_counter <= reg_overflow_counter + 1'b1;
      reg_diagnostics        <= diag_nxt;
      reg_control_clear_mask <= {30'h0, clr, 1'b0};
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Randomized and directed bench for adc_frame_packer against a sample-level
// reference model (FRAME_WORDS=4, FIFO_DEPTH=8).
module tb_adc_frame_packer;

  localparam int FW    = 4;
  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        adc_valid;
  logic [15:0] adc_data;
  logic [31:0] reg_control;
  logic [31:0] reg_frame_counter;
  logic [31:0] reg_overflow_counter;
  logic [31:0] reg_diagnostics;
  logic [31:0] reg_control_clear_mask;

  adc_frame_packer_if m_axis ();

  adc_frame_packer #(.FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .adc_valid              (adc_valid),
    .adc_data               (adc_data),
    .reg_control            (reg_control),
    .reg_frame_counter      (reg_frame_counter),
    .reg_overflow_counter   (reg_overflow_counter),
    .reg_diagnostics        (reg_diagnostics),
    .reg_control_clear_mask (reg_control_clear_mask),
    .m_axis                 (m_axis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: expected FIFO contents as {tlast, data}, frame progress in samples.
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  int          m_mode;
  int          m_s;
  logic [15:0] m_lo;
  logic [31:0] m_frames;
  logic [31:0] m_ovf;
  logic [31:0] m_diag;
  bit          m_prev_clr;
  bit          hold_valid;
  logic [31:0] hold_data;
  bit          after_reset;

  task automatic model_reset();
    exp_q.delete();
    m_mode      = 0;
    m_s         = 0;
    m_lo        = '0;
    m_frames    = '0;
    m_ovf       = '0;
    m_diag      = '0;
    m_prev_clr  = 1'b0;
    hold_valid  = 1'b0;
    after_reset = 1'b1;
  endtask

  task automatic step(input bit rst, input bit vld, input logic [15:0] d,
                      input logic [31:0] ctl, input bit rdy);
    int lvl;
    bit run, clr, pop, pop_last, ovf_inc, last;
    @(negedge clk);
    check_val("tvalid", 32'(m_axis.tvalid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_val("tdata", m_axis.tdata, exp_q[0][31:0]);
      check_val("tlast", 32'(m_axis.tlast), 32'(exp_q[0][32]));
    end
    if (hold_valid) check_val("stall_tdata", m_axis.tdata, hold_data);
    if (after_reset) begin
      check_val("rst_tdata", m_axis.tdata, 32'h0);
      check_val("rst_tlast", 32'(m_axis.tlast), 32'h0);
      after_reset = 1'b0;
    end
    check_val("frame_cnt", reg_frame_counter, m_frames);
    check_val("ovf_cnt", reg_overflow_counter, m_ovf);
    check_val("clr_mask", reg_control_clear_mask, {30'h0, m_prev_clr, 1'b0});
    check_val("diag", reg_diagnostics, m_diag);

    if (!rst && m_axis.tvalid && rdy) obs_q.push_back({m_axis.tlast, m_axis.tdata});
    reset         = rst;
    adc_valid     = vld;
    adc_data      = d;
    reg_control   = ctl;
    m_axis.tready = rdy;

    if (rst) begin
      model_reset();
      return;
    end
    run     = ctl[0];
    clr     = ctl[1];
    lvl     = exp_q.size();
    m_diag  = {run, 2'(m_mode), 1'b0, 12'h0, 16'(lvl)};
    pop     = (lvl != 0) && rdy;
    pop_last = pop && exp_q[0][32];
    hold_valid = (lvl != 0) && !rdy;
    if (hold_valid) hold_data = exp_q[0][31:0];
    if (pop) void'(exp_q.pop_front());
    ovf_inc = 1'b0;
    case (m_mode)
      0: if (vld && run) begin
        m_s  = 1;
        m_lo = d;
        if (DEPTH - lvl >= FW) m_mode = 1;
        else begin
          m_mode  = 3;
          ovf_inc = 1'b1;
        end
      end
      1: if (!run) m_mode = 2;
         else if (vld) begin
           if (m_s % 2 == 1) begin
             last = (m_s + 1 == 2 * FW);
             exp_q.push_back({last, d, m_lo});
           end else m_lo = d;
           m_s++;
           if (m_s == 2 * FW) m_mode = 0;
         end
      2: begin
        if (m_s % 2 == 1) begin
          m_s++;
          last = (m_s == 2 * FW);
          exp_q.push_back({last, 16'h0, m_lo});
        end else begin
          m_s += 2;
          last = (m_s == 2 * FW);
          exp_q.push_back({last, 32'h0});
        end
        if (m_s == 2 * FW) m_mode = 0;
      end
      default: if (!run) m_mode = 0;
               else if (vld) begin
                 m_s++;
                 if (m_s == 2 * FW) m_mode = 0;
               end
    endcase
    if (clr) m_frames = '0;
    else if (pop_last) m_frames = m_frames + 1;
    if (clr) m_ovf = '0;
    else if (ovf_inc) m_ovf = m_ovf + 1;
    m_prev_clr = clr;
  endtask

  task automatic idle(input int n, input logic [31:0] ctl, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, ctl, rdy);
  endtask

  task automatic check_words(input string tag, input logic [32:0] exp [4]);
    check_val({tag, "_nwords"}, 32'(obs_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs_q.size()) begin
        check_val({tag, "_word"}, obs_q[i][31:0], exp[i][31:0]);
        check_val({tag, "_tlast"}, 32'(obs_q[i][32]), 32'(exp[i][32]));
      end
    end
  endtask

  logic [32:0] basic_exp [4];
  logic [32:0] abort_exp [4];
  logic [31:0] rnd_ctl;

  initial begin
    reset         = 1'b1;
    adc_valid     = 1'b0;
    adc_data      = '0;
    reg_control   = '0;
    m_axis.tready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);

    basic_exp = '{33'h0_00020001, 33'h0_00040003, 33'h0_00060005, 33'h1_00080007};
    abort_exp = '{33'h0_00020001, 33'h0_00000003, 33'h0_00000000, 33'h1_00000000};

    // Basic frame
    idle(2, 32'h0, 1'b1);
    obs_q.delete();
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 16'(i), 32'h1, 1'b1);
    idle(4, 32'h1, 1'b1);
    check_words("basic", basic_exp);
    check_val("basic_frames", reg_frame_counter, 32'd1);

    // Abort with padding
    step(1'b1, 1'b0, 16'h0, 32'h0, 1'b1);
    idle(1, 32'h0, 1'b1);
    obs_q.delete();
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 16'(i), 32'h1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'hBEEF, 32'h0, 1'b1);
    check_words("abort", abort_exp);
    check_val("abort_frames", reg_frame_counter, 32'd1);

    // Backpressure and overflow
    step(1'b1, 1'b0, 16'h0, 32'h0, 1'b1);
    idle(1, 32'h0, 1'b0);
    for (int i = 1; i <= 24; i++) step(1'b0, 1'b1, 16'(i), 32'h1, 1'b0);
    idle(2, 32'h1, 1'b0);
    check_val("bp_diag", reg_diagnostics, 32'h8000_0008);
    check_val("bp_ovf", reg_overflow_counter, 32'd1);
    obs_q.delete();
    idle(12, 32'h1, 1'b1);
    check_val("bp_words_out", 32'(obs_q.size()), 32'd8);
    check_val("bp_frames", reg_frame_counter, 32'd2);
    check_val("bp_fifo_err", 32'(reg_diagnostics[28]), 32'h0);

    // Clear counters across a tlast handshake
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 16'(i + 16'h100), 32'h1, 1'b0);
    idle(1, 32'h1, 1'b0);
    idle(2, 32'h1, 1'b1);
    step(1'b0, 1'b0, 16'h0, 32'h3, 1'b1);
    check_val("clr_mask_before", reg_control_clear_mask, 32'h0);
    step(1'b0, 1'b0, 16'h0, 32'h3, 1'b1);
    step(1'b0, 1'b0, 16'h0, 32'h1, 1'b1);
    check_val("clr_frames", reg_frame_counter, 32'h0);
    check_val("clr_ovf", reg_overflow_counter, 32'h0);
    check_val("clr_mask_after", reg_control_clear_mask, 32'h2);
    idle(2, 32'h1, 1'b1);

    // Reset mid-capture
    idle(1, 32'h1, 1'b0);
    step(1'b0, 1'b1, 16'hAAAA, 32'h1, 1'b0);
    step(1'b0, 1'b1, 16'hBBBB, 32'h1, 1'b0);
    step(1'b0, 1'b1, 16'hCCCC, 32'h1, 1'b0);
    step(1'b1, 1'b0, 16'h0, 32'h1, 1'b1);
    idle(1, 32'h1, 1'b1);
    obs_q.delete();
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 16'(i), 32'h1, 1'b1);
    idle(4, 32'h1, 1'b1);
    check_words("post_rst", basic_exp);

    // Random stimulus with stalls, RUN drops and clears
    for (int n = 0; n < 1500; n++) begin
      rnd_ctl      = $urandom;
      rnd_ctl[0]   = ($urandom_range(0, 99) < 97);
      rnd_ctl[1]   = ($urandom_range(0, 99) < 2);
      step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), rnd_ctl,
           1'($urandom_range(0, 2) != 0 ? 1 : ($urandom_range(0, 9) == 0)));
    end
    idle(40, 32'h0, 1'b1);
    check_val("drain_empty", 32'(m_axis.tvalid), 32'h0);
    check_val("rand_fifo_err", 32'(reg_diagnostics[28]), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
